// File: rtl/keccak_msg_framer_if.sv
// Handshake bundle between the host-side adapter and the Keccak message framer:
// command, raw message source, framed output and status.
interface keccak_msg_framer_if #(
  parameter int LEN_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_msg_bits;
  logic [28:0]      cmd_out_bits;
  logic             src_valid;
  logic             src_ready;
  logic [63:0]      src_data;
  logic             dout_valid;
  logic             dout_ready;
  logic [63:0]      dout;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_mode, cmd_msg_bits, cmd_out_bits,
    output src_valid, src_data, dout_ready,
    input  cmd_ready, src_ready, dout_valid, dout, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_msg_bits, cmd_out_bits,
    input  src_valid, src_data, dout_ready,
    output cmd_ready, src_ready, dout_valid, dout, busy, done
  );
endinterface

// File: rtl/keccak_msg_framer.sv
// Splits a message into segments of at most SEG_BITS and emits, per segment,
// one header word followed by its data words through a single output register.
module keccak_msg_framer #(
  parameter int SEG_BITS = 1088,
  parameter int LEN_W    = 32
) (
  input  logic clk,
  input  logic rst,
  keccak_msg_framer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, FIN} state_t;

  localparam logic [LEN_W-1:0] SEG_LEN = LEN_W'(SEG_BITS);

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [28:0]      out_bits_reg, out_bits_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic [LEN_W-1:0] words_left_reg, words_left_next;
  logic [5:0]       tail_reg, tail_next;
  logic [63:0]      dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             out_free;
  logic             src_hs;
  logic             seg_final;
  logic [LEN_W-1:0] seg_len;
  logic [LEN_W-1:0] seg_words;
  logic [63:0]      tail_mask;

  assign out_free  = !dout_valid_reg || bus.dout_ready;
  assign seg_final = (rem_reg <= SEG_LEN);
  assign seg_len   = seg_final ? rem_reg : SEG_LEN;
  assign seg_words = (seg_len + LEN_W'(63)) >> 6;

  // Only the final segment can end mid-word; tail_reg is 0 for full segments.
  assign tail_mask = (tail_reg != 6'd0 && words_left_reg == LEN_W'(1))
                     ? ~(64'hFFFF_FFFF_FFFF_FFFF >> tail_reg)
                     : 64'hFFFF_FFFF_FFFF_FFFF;

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.src_ready  = (state_reg == DATA) && out_free;
  assign src_hs         = bus.src_valid && bus.src_ready;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      mode_reg       <= '0;
      out_bits_reg   <= '0;
      rem_reg        <= '0;
      words_left_reg <= '0;
      tail_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      out_bits_reg   <= out_bits_next;
      rem_reg        <= rem_next;
      words_left_reg <= words_left_next;
      tail_reg       <= tail_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    out_bits_next   = out_bits_reg;
    rem_next        = rem_reg;
    words_left_next = words_left_reg;
    tail_next       = tail_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          mode_next       = bus.cmd_mode;
          out_bits_next   = bus.cmd_out_bits;
          rem_next        = {bus.cmd_msg_bits[LEN_W-1:3], 3'b000};
          words_left_next = '0;
          tail_next       = '0;
          busy_next       = 1'b1;
          state_next      = HDR;
        end
      end
      HDR: begin
        if (out_free) begin
          dout_next       = {seg_final, mode_reg, out_bits_reg, 32'(seg_len)};
          dout_valid_next = 1'b1;
          words_left_next = seg_words;
          rem_next        = rem_reg - seg_len;
          tail_next       = seg_final ? seg_len[5:0] : 6'd0;
          state_next      = (seg_words != '0) ? DATA : FIN;
        end
      end
      DATA: begin
        if (src_hs && words_left_reg != '0) begin
          dout_next       = bus.src_data & tail_mask;
          dout_valid_next = 1'b1;
          words_left_next = words_left_reg - LEN_W'(1);
          if (words_left_reg == LEN_W'(1))
            state_next = (rem_reg != '0) ? HDR : FIN;
        end else if (out_free) begin
          dout_valid_next = 1'b0;
        end
      end
      FIN: begin
        if (out_free) begin
          dout_valid_next = 1'b0;
          done_next       = 1'b1;
          busy_next       = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: doc/keccak_msg_framer.md
Name: keccak_msg_framer

Overview:
- Host-side transmitter for the Keccak core's 64-bit input word protocol.
- Accepts a hash command (mode, message length, output length) and a stream of raw 64-bit message words.
- Emits the framed word stream the Keccak datapath consumes: for each segment, one header word followed by that segment's data words. The final segment's header carries the final flag.
- Sits between the host/bus adapter and the Keccak datapath input port. Uses valid/ready on every side.

Parameters:
- SEG_BITS, 1088, maximum segment payload in bits; multiple of 64, range 64..65472.
- LEN_W, 32, width of the message-length and remaining-bit counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_mode  in  2  00 SHA3-256, 01 SHA3-512, 10 SHAKE128, 11 SHAKE256; copied to header bits 62:61
- cmd_msg_bits  in  32  message length in bits; bits 2:0 ignored (treated as 0)
- cmd_out_bits  in  29  requested output length in bits; copied to header bits 60:32
- src_valid  in  1  message word present
- src_ready  out  1  message word taken when src_valid && src_ready
- src_data  in  64  message word; first byte in bits 63:56
- dout_valid  out  1  framed word present
- dout_ready  in  1  sink accepts the word when dout_valid && dout_ready
- dout  out  64  framed word (header or data)
- busy  out  1  high from command acceptance until done
- done  out  1  one-cycle pulse after the last framed word handshakes

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, dout_valid=0, dout=0, done=0, busy=0, all counters 0. cmd_ready=1 and src_ready=0 follow combinationally from IDLE.
- Output register: dout/dout_valid form a single register. It loads when free, i.e. !dout_valid || dout_ready.
  - dout and dout_valid are held stable while dout_valid && !dout_ready.
  - Throughput is one word per cycle with no bubbles, including header-to-data and data-to-header transitions.
- cmd_ready = (state==IDLE).
- On command acceptance: latch mode, out_bits, and rem = msg_bits with bits 2:0 cleared. Set busy. Next state HDR.
- HDR, when the output register is free: load the header word.
  - Header fields: bit63 = final, 62:61 = mode, 60:32 = out_bits, 31:0 = seg_len.
  - seg_len = min(rem, SEG_BITS); final = (rem <= SEG_BITS).
  - Set words_left = ceil(seg_len/64); rem -= seg_len.
  - Next state: DATA if words_left > 0, else FIN.
- DATA:
  - src_ready = (state==DATA) && (!dout_valid || dout_ready). It is combinational and never asserted outside DATA.
  - On a source handshake: load src_data into dout and decrement words_left.
  - On the last word of the final segment with seg_len mod 64 = b != 0: keep the top b bits and zero bits 63-b..0.
  - After the last word of a segment: next state HDR if rem > 0, else FIN.
- FIN: when the output register empties (dout_valid=0, or a handshake this cycle), pulse done for one cycle, clear busy, return to IDLE. A new command is accepted no earlier than the cycle after done.
- Zero-length message: one header only, 0x8000_0000_0000_0000 | mode<<61 | out_bits<<32, with seg_len = 0. No source words are taken.
- Message length an exact multiple of SEG_BITS: the last segment is full and carries final=1. No empty trailing segment is emitted.
- Backpressure on dout stalls source acceptance in the same cycle. No word is dropped or duplicated.
- src_valid low in DATA: the output register drains and dout_valid goes 0 until the next source word arrives.
- Reset asserted mid-message: immediate return to reset values; the partial frame is abandoned. No done pulse is produced.
- Counters are unsigned and never underflow: words_left is decremented only when > 0, and rem only by seg_len <= rem.

Test Plan:
- mode=01, msg_bits=0, out_bits=512, dout_ready=1 -> exactly one word, 0xA000_0200_0000_0000; src_ready never high; done one cycle later.
- mode=00, msg_bits=200, out_bits=256 -> header 0x8000_0100_0000_00C8, then 4 data words; 4th word bits 55:0 zeroed; done pulses.
- mode=10, msg_bits=2176 (2×1088), SEG_BITS=1088 -> header 0x4000_0000_0000_0440 (final=0), then 17 words, then header with bit63=1 and len 0x440, then 17 words; no third header.
- Same stimulus as the previous test with dout_ready toggling 1,0,0,1 -> word sequence identical to the unstalled run; dout stable across every stalled cycle; source words taken = 34.
- rst pulsed low after 5 data words of a 1088-bit message -> dout_valid=0, busy=0, cmd_ready=1 immediately; a following 64-bit command frames correctly.
- msg_bits=70 (low bits 110) -> treated as 64; header len field 0x40; 1 data word.
